// File: rtl/spi_io_pkg.sv
`timescale 1ns/1ps
// Shared constants for the SPI slave I/O slice.
package spi_io_pkg;

    // Default word length, MSB first.
    localparam int unsigned SPI_WORD_W   = 16;
    // Bit counter width for the default word length.
    localparam int unsigned SPI_CNT_W    = $clog2(SPI_WORD_W);
    // Fewest synchroniser stages allowed on the asynchronous pins.
    localparam int unsigned SPI_SYNC_MIN = 2;

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// N-stage synchroniser with registered rise/fall pulses.
import spi_io_pkg::*;

module spi_sync_edge #(
    parameter int unsigned STAGES  = SPI_SYNC_MIN,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Edges come from the last two stages so each pulse lines up with the
    // cycle in which dout first shows the new level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
        fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end

    // Synchroniser and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_io.sv
`timescale 1ns/1ps
// SPI mode-0 slave I/O: oversampled sclk/cs/mosi, word receive and transmit.
import spi_io_pkg::*;

module spi_io #(
    parameter int unsigned WIDTH       = SPI_WORD_W,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_MIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync;

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-2:0]       rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   miso_q, miso_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .dout  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs),
        .dout  (cs_sync),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

    // Receive/transmit shifting, bit count and word hand-off.
    // The tx register holds the bits still to be driven: on cs_fall the MSB
    // goes straight to miso and the remainder is pre-shifted, so every sclk
    // fall simply drives tx_shift[MSB]; the word-end reload of the full
    // tx_data then makes the next fall drive the new word's MSB.
    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;

        if (cs_fall) begin
            tx_shift_d = tx_data << 1;
            miso_d     = tx_data[WIDTH-1];
            cnt_d      = '0;
        end else if (cs_rise) begin
            // Any partial word is dropped; a same-cycle sclk_rise is ignored.
            cnt_d  = '0;
            miso_d = 1'b0;
        end else if (!cs_sync) begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_sync};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d      = '0;
                    rx_data_d  = {rx_shift_q, mosi_sync};
                    rx_valid_d = 1'b1;
                    tx_shift_d = tx_data;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (sclk_fall) begin
                miso_d     = tx_shift_q[WIDTH-1];
                tx_shift_d = tx_shift_q << 1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    // sclk level itself is only consumed through its edge pulses.
    logic unused_sclk_level;
    assign unused_sclk_level = sclk_sync;

endmodule

// File: tb/tb_spi_io.sv
`timescale 1ns/1ps
// Directed bench for spi_io: 100 MHz fabric clock, 5 MHz SPI master model.
module tb_spi_io;

    logic        clk = 1'b0;
    logic        rst_n, sclk, cs, mosi, miso, rx_valid;
    logic [15:0] rx_data, tx_data, tx_fixed;
    logic        loop_en;

    int   n_vec = 0, n_err = 0;
    int   vld_pulses = 0, vld_cycles = 0;
    logic vld_prev = 1'b0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    assign tx_data = loop_en ? ~rx_data : tx_fixed;

    spi_io #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .rx_valid (rx_valid)
    );

    // rx_valid pulse and high-cycle tally, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid && !vld_prev) vld_pulses++;
        if (rx_valid) vld_cycles++;
        vld_prev = rx_valid;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One mode-0 bit: drive mosi, half period, sample miso, rise, half period, fall.
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #100;
        r = miso;
        sclk = 1'b1;
        #100;
        sclk = 1'b0;
    endtask

    // Full cs-low frame of nbits, MSB first; returns what the master read.
    task automatic spi_xfer(input logic [31:0] w, input int nbits, output logic [31:0] r);
        logic b;
        r  = '0;
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[nbits-1-i], b);
            r = {r[30:0], b};
        end
        #100;
        cs   = 1'b1;
        mosi = 1'b0;
        #400;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: run did not complete, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        int   p0;
        rst_n    = 1'b0;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        loop_en  = 1'b0;
        tx_fixed = 16'hFFFF;

        // Reset with sclk toggling.
        #3;
        repeat (10) #10 sclk = ~sclk;
        sclk = 1'b0;
        @(negedge clk);
        check_val("rst_rx_data", {16'h0, rx_data}, 32'h0);
        check_val("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check_val("rst_miso", {31'h0, miso}, 32'h0);
        rst_n = 1'b1;
        #203;

        // Single word.
        spi_xfer(32'h0000_1234, 16, rd);
        check_val("single_miso", rd, 32'h0000_FFFF);
        check_val("single_rx", {16'h0, rx_data}, 32'h0000_1234);
        check_val("single_vld", vld_pulses, 1);

        // Loopback: tx_data = ~rx_data.
        loop_en = 1'b1;
        spi_xfer(32'h0000_1234, 16, rd);
        check_val("loop1_miso", rd, 32'h0000_EDCB);
        spi_xfer(32'h0000_00FF, 16, rd);
        check_val("loop2_miso", rd, 32'h0000_EDCB);
        check_val("loop_rx", {16'h0, rx_data}, 32'h0000_00FF);
        check_val("loop_vld", vld_pulses, 3);

        // Partial word of 9 bits is discarded.
        spi_xfer(32'h0000_01AB, 9, rd);
        check_val("partial_rx", {16'h0, rx_data}, 32'h0000_00FF);
        check_val("partial_vld", vld_pulses, 3);

        // Two back-to-back words in one frame, fixed tx word reloaded.
        loop_en  = 1'b0;
        tx_fixed = 16'h3C96;
        spi_xfer(32'hA5A5_5A5A, 32, rd);
        check_val("cont_miso", rd, 32'h3C96_3C96);
        check_val("cont_rx", {16'h0, rx_data}, 32'h0000_5A5A);
        check_val("cont_vld", vld_pulses, 5);

        // Reset after 8 bits of a word, then a full new word.
        loop_en = 1'b1;
        p0 = vld_pulses;
        cs = 1'b0;
        for (int i = 0; i < 8; i++) spi_bit(i[0], b);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_val("midrst_rx", {16'h0, rx_data}, 32'h0);
        check_val("midrst_miso", {31'h0, miso}, 32'h0);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #203;
        check_val("midrst_novld", vld_pulses, p0);
        spi_xfer(32'h0000_BEEF, 16, rd);
        check_val("beef_miso", rd, 32'h0000_FFFF);
        check_val("beef_rx", {16'h0, rx_data}, 32'h0000_BEEF);
        check_val("beef_vld", vld_pulses, p0 + 1);

        // Every pulse lasted exactly one clock.
        check_val("vld_width", vld_cycles, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
